// File: rtl/pe_scan_if.sv
// Handshake bundle for pe_scan: request-vector capture side and index-beat side.
//   in_valid/in_ready/in_data/msb_first : vector capture handshake and order select
//   out_valid/out_ready                 : beat handshake
//   out_idx/out_none/out_last           : beat payload
// slave is the scanner; master is the producer/consumer pair around it.
interface pe_scan_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned IDXW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             msb_first;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_idx;
    logic             out_none;
    logic             out_last;

    modport master (
        output in_valid, in_data, msb_first, out_ready,
        input  in_ready, out_valid, out_idx, out_none, out_last
    );

    modport slave (
        input  in_valid, in_data, msb_first, out_ready,
        output in_ready, out_valid, out_idx, out_none, out_last
    );
endinterface

// File: rtl/pe_scan.sv
// Sequential priority scanner: captures a WIDTH-bit request vector and emits the
// index of every set bit, one beat per accepted handshake, highest or lowest first.
// An all-zero vector yields a single beat flagged out_none.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : pe_scan_if slave (capture handshake in, index beats out; all outputs registered)
module pe_scan #(
    parameter int unsigned WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    pe_scan_if.slave  bus
);
    localparam int unsigned IDXW = $clog2(WIDTH);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] pend, pend_nx;
    logic             mode, mode_nx;
    logic             none, none_nx;

    // Index of the highest (msb=1) or lowest (msb=0) set bit; 0 for an empty mask.
    function automatic logic [IDXW-1:0] pick(input logic [WIDTH-1:0] p, input logic msb);
        logic [IDXW-1:0] r;
        r = '0;
        if (msb) begin
            for (int i = 0; i < int'(WIDTH); i++)
                if (p[i]) r = IDXW'(i);
        end else begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--)
                if (p[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    // True when exactly one bit remains pending.
    function automatic logic one_left(input logic [WIDTH-1:0] p);
        return (p != '0) && ((p & (p - WIDTH'(1))) == '0);
    endfunction

    // Next-state: capture in IDLE, retire the presented bit on each accepted beat.
    always_comb begin
        state_nx = state;
        pend_nx  = pend;
        mode_nx  = mode;
        none_nx  = none;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    pend_nx  = bus.in_data;
                    mode_nx  = bus.msb_first;
                    none_nx  = (bus.in_data == '0);
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    pend_nx = pend & ~(WIDTH'(1) << bus.out_idx);
                    if (bus.out_last) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and outputs; outputs are precomputed from next state so they stay registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            pend          <= '0;
            mode          <= 1'b0;
            none          <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_idx   <= '0;
            bus.out_none  <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            state         <= state_nx;
            pend          <= pend_nx;
            mode          <= mode_nx;
            none          <= none_nx;
            bus.in_ready  <= (state_nx == IDLE);
            bus.out_valid <= (state_nx == SCAN);
            bus.out_idx   <= (state_nx == SCAN && !none_nx) ? pick(pend_nx, mode_nx) : '0;
            bus.out_none  <= (state_nx == SCAN) && none_nx;
            bus.out_last  <= (state_nx == SCAN) && (none_nx || one_left(pend_nx));
        end
    end
endmodule

// File: tb/tb_pe_scan.sv
// Bench for pe_scan: WIDTH=8 and WIDTH=5 instances, list-of-indices model, per-cycle compare.
module tb_pe_scan;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pe_scan_if #(.WIDTH(8)) b8 ();
    pe_scan_if #(.WIDTH(5)) b5 ();

    pe_scan #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    pe_scan #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst), .bus(b5.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected beats still owed per instance; -1 stands for the all-zero report.
    int q8[$];
    int q5[$];
    // Beats the DUT actually delivered (sampled at the accepting edge).
    int li0[$], ll0[$], ln0[$];
    int li1[$], ll1[$], ln1[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input int pat, input int k);
        if (pat == 0) return 1'b1;
        return (k % 6 == 0) || (k % 6 == 3) || (k % 6 == 5);
    endfunction

    // Model update on each edge: expand a captured vector into its index list.
    always @(posedge clk or negedge rst) begin : mon8
        int j;
        if (!rst) q8.delete();
        else if (q8.size() == 0) begin
            if (b8.in_valid) begin
                if (b8.in_data == '0) q8.push_back(-1);
                else for (int i = 0; i < 8; i++) begin
                    j = b8.msb_first ? 7 - i : i;
                    if (b8.in_data[j]) q8.push_back(j);
                end
            end
        end else if (b8.out_ready) begin
            li0.push_back(int'(b8.out_idx));
            ll0.push_back(int'(b8.out_last));
            ln0.push_back(int'(b8.out_none));
            void'(q8.pop_front());
        end
    end

    always @(posedge clk or negedge rst) begin : mon5
        int j;
        if (!rst) q5.delete();
        else if (q5.size() == 0) begin
            if (b5.in_valid) begin
                if (b5.in_data == '0) q5.push_back(-1);
                else for (int i = 0; i < 5; i++) begin
                    j = b5.msb_first ? 4 - i : i;
                    if (b5.in_data[j]) q5.push_back(j);
                end
            end
        end else if (b5.out_ready) begin
            li1.push_back(int'(b5.out_idx));
            ll1.push_back(int'(b5.out_last));
            ln1.push_back(int'(b5.out_none));
            void'(q5.pop_front());
        end
    end

    // Compare DUT outputs against the model every cycle out of reset.
    always @(negedge clk) begin
        if (rst) begin
            chk("valid8", int'(b8.out_valid), int'(q8.size() != 0));
            chk("ready8", int'(b8.in_ready), int'(q8.size() == 0));
            if (q8.size() != 0) begin
                chk("idx8", int'(b8.out_idx), (q8[0] < 0) ? 0 : q8[0]);
                chk("none8", int'(b8.out_none), int'(q8[0] < 0));
                chk("last8", int'(b8.out_last), int'(q8.size() == 1));
            end
            chk("valid5", int'(b5.out_valid), int'(q5.size() != 0));
            chk("ready5", int'(b5.in_ready), int'(q5.size() == 0));
            if (q5.size() != 0) begin
                chk("idx5", int'(b5.out_idx), (q5[0] < 0) ? 0 : q5[0]);
                chk("none5", int'(b5.out_none), int'(q5[0] < 0));
                chk("last5", int'(b5.out_last), int'(q5.size() == 1));
                chk("idx5_range", int'(b5.out_idx < 3'd5), 1);
            end
        end
    end

    // Present one vector, then drive out_ready by pattern until drained (or stop beats taken).
    task automatic send(input int d, input logic [7:0] v, input logic m, input int pat,
                        input int stop, input logic pulse, output int ncyc);
        int k;
        if (d == 0) begin
            li0.delete(); ll0.delete(); ln0.delete();
            b8.in_valid = 1'b1; b8.in_data = v; b8.msb_first = m;
        end else begin
            li1.delete(); ll1.delete(); ln1.delete();
            b5.in_valid = 1'b1; b5.in_data = v[4:0]; b5.msb_first = m;
        end
        @(negedge clk);
        b8.in_valid = 1'b0; b5.in_valid = 1'b0;
        b8.msb_first = ~m;  b5.msb_first = ~m;
        k = 0;
        while (((d == 0) ? q8.size() : q5.size()) != 0
               && (stop == 0 || ((d == 0) ? li0.size() : li1.size()) < stop) && k < 200) begin
            if (d == 0) b8.out_ready = rdy(pat, k);
            else begin
                b5.out_ready = rdy(pat, k);
                b5.in_valid  = pulse && (k == 0);
                b5.in_data   = pulse ? 5'b00011 : b5.in_data;
            end
            @(negedge clk);
            k++;
        end
        b5.in_valid = 1'b0;
        if (k >= 200) chk("timeout", 1, 0);
        ncyc = k;
    endtask

    initial begin
        int n;
        checks = 0; failures = 0;
        rst = 1'b0;
        b8.in_valid = 1'b0; b8.in_data = '0; b8.msb_first = 1'b0; b8.out_ready = 1'b0;
        b5.in_valid = 1'b0; b5.in_data = '0; b5.msb_first = 1'b0; b5.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(b8.in_ready), 1);
        chk("rst_valid", int'(b8.out_valid), 0);
        chk("rst_idx", int'(b8.out_idx), 0);
        chk("rst_none", int'(b8.out_none), 0);
        chk("rst_last", int'(b8.out_last), 0);
        rst = 1'b1;
        @(negedge clk);

        // 8'b1000_0001, MSB first
        send(0, 8'h81, 1'b1, 0, 0, 1'b0, n);
        chk("t1_cycles", n, 2);
        chk("t1_n", li0.size(), 2);
        chk("t1_idx0", li0[0], 7); chk("t1_last0", ll0[0], 0); chk("t1_none0", ln0[0], 0);
        chk("t1_idx1", li0[1], 0); chk("t1_last1", ll0[1], 1); chk("t1_none1", ln0[1], 0);
        chk("t1_ready_after", int'(b8.in_ready), 1);

        // same vector, LSB first
        send(0, 8'h81, 1'b0, 0, 0, 1'b0, n);
        chk("t2_idx0", li0[0], 0); chk("t2_last0", ll0[0], 0);
        chk("t2_idx1", li0[1], 7); chk("t2_last1", ll0[1], 1);

        // all-zero vector
        send(0, 8'h00, 1'b1, 0, 0, 1'b0, n);
        chk("t3_n", li0.size(), 1);
        chk("t3_idx", li0[0], 0); chk("t3_none", ln0[0], 1); chk("t3_last", ll0[0], 1);
        chk("t3_cycles", n, 1);

        // 8'hFF with stalls: accepts at k=0,3,5,6,9,11,12,15
        send(0, 8'hFF, 1'b1, 1, 0, 1'b0, n);
        chk("t4_cycles", n, 16);
        chk("t4_n", li0.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("t4_idx", li0[i], 7 - i);
            chk("t4_last", ll0[i], int'(i == 7));
        end

        // 8'b0101_1010, LSB first
        send(0, 8'h5A, 1'b0, 0, 0, 1'b0, n);
        chk("t7_n", li0.size(), 4);
        chk("t7_idx0", li0[0], 1); chk("t7_idx1", li0[1], 3);
        chk("t7_idx2", li0[2], 4); chk("t7_idx3", li0[3], 6);

        // 8'hF0 LSB first, reset after two beats
        send(0, 8'hF0, 1'b0, 0, 2, 1'b0, n);
        chk("t5_n", li0.size(), 2);
        chk("t5_idx0", li0[0], 4); chk("t5_idx1", li0[1], 5);
        chk("t5_pre_valid", int'(b8.out_valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_valid", int'(b8.out_valid), 0);
        chk("t5_async_ready", int'(b8.in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        b8.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_no_residual", int'(b8.out_valid), 0);

        // WIDTH=5: 5'b10100 LSB first, in_valid pulsed mid-scan with 5'b00011
        send(1, 8'h14, 1'b0, 0, 0, 1'b1, n);
        chk("t6_n", li1.size(), 2);
        chk("t6_idx0", li1[0], 2); chk("t6_last0", ll1[0], 0);
        chk("t6_idx1", li1[1], 4); chk("t6_last1", ll1[1], 1);
        repeat (2) @(negedge clk);
        chk("t6_idle_valid", int'(b5.out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pe_scan.md
Name: pe_scan

Overview:
Parametrised, sequential successor to the team's 8-bit registered priority encoder. It captures a WIDTH-bit request vector through a valid/ready handshake. It then emits the index of every set bit, one per beat, in a selectable priority order (MSB-first or LSB-first). An all-zero vector is reported explicitly with a flag rather than left undefined. It sits between request-collection logic and a per-request consumer, such as an interrupt or a service dispatcher.

Parameters:
WIDTH, 8, request vector width; legal range 2..256, non-power-of-two allowed.
IDXW, $clog2(WIDTH), index width; derived from WIDTH, never overridden.

Ports:
clk        input   1      rising-edge clock
rst        input   1      asynchronous, active-low reset
in_valid   input   1      request vector present
in_ready   output  1      block can accept a vector
in_data    input   WIDTH  request vector; bit i set = request i
msb_first  input   1      order select; 1 = highest index first, 0 = lowest first; sampled with in_data
out_valid  output  1      out_idx/out_none/out_last valid
out_ready  input   1      consumer accepts current beat
out_idx    output  IDXW   index of current highest-priority pending bit
out_none   output  1      captured vector was all-zero
out_last   output  1      current beat is final beat for this vector

Behaviour:
- Reset (rst low, asynchronous, any state):
  - state = IDLE; pending mask, mode and none flag cleared.
  - in_ready = 1; out_valid = 0, out_idx = 0, out_none = 0, out_last = 0.
  - On release, the block is in IDLE; no residual beats.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - SCAN: in_ready = 0, out_valid = 1.
- IDLE -> SCAN on in_valid && in_ready at edge T:
  - pending <= in_data; mode <= msb_first; none <= (in_data == 0).
  - First beat is valid from T+1. Capture latency is one cycle.
- in_valid while in SCAN is ignored; the upstream holds it per handshake.
- All outputs are derived only from registered state. No combinational path from in_* or out_ready to out_*.
- out_idx selection:
  - mode = 1: index of highest set bit of pending.
  - mode = 0: index of lowest set bit of pending.
  - none = 1: out_idx = 0, out_none = 1.
- out_last = 1 when pending has exactly one bit set, or when none = 1.
- Beat accepted on out_valid && out_ready:
  - Clear the selected bit in pending.
  - If out_last, go to IDLE at the same edge, so in_ready = 1 in the following cycle.
- Stall (out_ready = 0): out_idx/out_none/out_last held stable; pending unchanged.
- Throughput:
  - N set bits produce exactly N beats; a zero vector produces exactly 1 beat.
  - Beats are back-to-back while out_ready = 1.
  - One idle cycle between vectors, so the minimum cycles per vector is max(N,1) + 1.
- mode is latched per vector. Toggling msb_first mid-scan has no effect.
- WIDTH non-power-of-two: out_idx never exceeds WIDTH-1.
- Reset mid-scan aborts the scan immediately; remaining indices are discarded.

Test Plan:
1. WIDTH=8, in_data=8'b1000_0001, msb_first=1, out_ready=1 -> beats idx=7 (last=0), idx=0 (last=1), out_none=0; in_ready=1 on the cycle after the second beat.
2. Same vector, msb_first=0 -> idx=0 (last=0), then idx=7 (last=1).
3. in_data=8'h00 -> single beat: out_none=1, idx=0, last=1; then IDLE.
4. in_data=8'hFF, msb_first=1, out_ready pattern 1,0,0,1,0,1,... -> 8 beats idx 7..0 in order; outputs stable during every stall cycle; last=1 only on idx 0.
5. in_data=8'hF0, msb_first=0; accept 2 beats (4, 5), then pull rst low between edges -> out_valid=0 and in_ready=1 immediately (asynchronous); after release, no beats until a new vector is accepted.
6. WIDTH=5 instance, in_data=5'b10100, msb_first=0 -> idx=2 (last=0), idx=4 (last=1); IDXW=3; in_valid pulsed during SCAN with 5'b00011 is ignored.
